// File: rtl/adder_pipe_pkg.sv
// -----------------------------------------------------------------------------
// adder_pipe_pkg
//   Constants and helpers shared by the pipelined add/subtract unit.
//   ADD_MODE / SUB_MODE : encodings of the 'sub' mode input.
//   split_ok()          : legality of a WIDTH/STAGES split. The top module
//                         calls it at elaboration and stops with an error on
//                         an illegal pair.
// -----------------------------------------------------------------------------
package adder_pipe_pkg;

  localparam logic ADD_MODE = 1'b0;
  localparam logic SUB_MODE = 1'b1;

  // A split is legal when every stage gets a whole, non-empty chunk.
  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_pipe_chunk.sv
// -----------------------------------------------------------------------------
// addbit
//   One-bit full adder cell, the building block of the ripple chains.
//   Ports: a, b, ci (inputs); s = sum bit, co = carry out (outputs).
//
// adder_chunk
//   Combinational CHUNK-bit ripple adder made of addbit cells.
//   Ports: a, b [CHUNK]  operands
//          c             carry in
//          s  [CHUNK]    sum
//          co            carry out of the chunk MSB
//          cmsb          carry into the chunk MSB (used to form signed overflow)
// -----------------------------------------------------------------------------
module addbit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cmsb
);

  // carry[i] is the carry into bit i; carry[CHUNK] leaves the chunk.
  logic [CHUNK:0] carry;

  assign carry[0] = c;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    addbit u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (s[i]),
      .co (carry[i+1])
    );
  end

  assign co   = carry[CHUNK];
  assign cmsb = carry[CHUNK-1];

endmodule

// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe
//   Pipelined WIDTH-bit add/subtract unit. The operands are split into STAGES
//   chunks; stage k resolves chunk k using the carry registered by stage k-1.
//   Latency STAGES cycles, throughput one beat per cycle, bubble-collapsing
//   valid/ready flow control at both ends.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready has no path from in_valid)
//   a, b [WIDTH]          operands
//   cin                   carry in, add mode only
//   sub                   0: a+b+cin, 1: a-b (a + ~b + 1, cin ignored)
//   out_valid / out_ready output handshake
//   sum [WIDTH]           result modulo 2^WIDTH (0 while out_valid is low)
//   cout                  carry out of the MSB (sub mode: 1 = no borrow)
//   overflow              signed overflow
// -----------------------------------------------------------------------------
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("adder_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  // ready[k] is the load enable of stage k; ready[STAGES] is the consumer.
  logic [STAGES:0]   ready;
  logic [STAGES-1:0] valid;

  // Subtraction is folded into an add at pipeline entry.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign b_eff = (sub == SUB_MODE) ? ~b  : b;
  assign c_eff = (sub == ADD_MODE) ? cin : 1'b1;

  assign ready[STAGES] = out_ready;
  assign in_ready      = ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Operand bits not yet consumed when a beat enters stage k.
    localparam int SW = WIDTH - k * CHUNK;
    // Result bits already resolved once a beat leaves stage k.
    localparam int RW = (k + 1) * CHUNK;

    logic [SW-1:0]    src_a;
    logic [SW-1:0]    src_b;
    logic             src_c;
    logic             src_valid;
    logic [CHUNK-1:0] s;
    logic             co;
    logic             cmsb;

    logic             valid_q;
    logic             carry_q;
    logic [RW-1:0]    res_q;

    assign valid[k] = valid_q;
    // An empty stage can always load; a full one only if its successor moves.
    assign ready[k] = !valid_q || ready[k+1];

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (src_a[CHUNK-1:0]),
      .b    (src_b[CHUNK-1:0]),
      .c    (src_c),
      .s    (s),
      .co   (co),
      .cmsb (cmsb)
    );

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's value from before the edge.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
      end else if (ready[k]) begin
        valid_q <= src_valid;
      end
    end

    // NOTE: only the valid bits are reset; data registers of an empty stage
    // are never observed, and the outputs are masked by out_valid.
    always_ff @(posedge clk) begin
      if (ready[k]) begin
        carry_q <= co;
      end
    end

    if (k == 0) begin : g_src
      assign src_a     = a;
      assign src_b     = b_eff;
      assign src_c     = c_eff;
      assign src_valid = in_valid;

      always_ff @(posedge clk) begin
        if (ready[k]) begin
          res_q <= s;
        end
      end
    end else begin : g_src
      assign src_a     = g_st[k-1].g_rem.a_q;
      assign src_b     = g_st[k-1].g_rem.b_q;
      assign src_c     = g_st[k-1].carry_q;
      assign src_valid = valid[k-1];

      always_ff @(posedge clk) begin
        if (ready[k]) begin
          res_q <= {s, g_st[k-1].res_q};
        end
      end
    end

    if (k < STAGES - 1) begin : g_rem
      // Upper operand bits travel with the beat until their stage is reached.
      logic [SW-CHUNK-1:0] a_q;
      logic [SW-CHUNK-1:0] b_q;
      logic                cmsb_unused;

      assign cmsb_unused = cmsb;

      always_ff @(posedge clk) begin
        if (ready[k]) begin
          a_q <= src_a[SW-1:CHUNK];
          b_q <= src_b[SW-1:CHUNK];
        end
      end
    end else begin : g_end
      // The last stage keeps the carry into the MSB to form signed overflow.
      logic cmsb_q;

      always_ff @(posedge clk) begin
        if (ready[k]) begin
          cmsb_q <= cmsb;
        end
      end
    end
  end

  assign out_valid = valid[STAGES-1];
  assign sum       = out_valid ? g_st[STAGES-1].res_q : '0;
  assign cout      = out_valid & g_st[STAGES-1].carry_q;
  assign overflow  = out_valid & (g_st[STAGES-1].g_end.cmsb_q ^ g_st[STAGES-1].carry_q);

endmodule

// File: tb/tb_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe
//   Self-checking bench for adder_pipe at WIDTH=16 with STAGES = 4, 1 and 16.
//   Instance 0 (STAGES=4) gets the streaming, back-pressure and reset tests;
//   all three instances run the directed vector table.
// -----------------------------------------------------------------------------
module tb_adder_pipe;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_ready;

  logic         iv [3];
  logic         ir [3];
  logic         ov [3];
  logic [W-1:0] sm [3];
  logic         co [3];
  logic         of [3];

  adder_pipe #(.WIDTH(W), .STAGES(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[0]), .out_ready(out_ready),
    .sum(sm[0]), .cout(co[0]), .overflow(of[0])
  );

  adder_pipe #(.WIDTH(W), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[1]), .out_ready(out_ready),
    .sum(sm[1]), .cout(co[1]), .overflow(of[1])
  );

  adder_pipe #(.WIDTH(W), .STAGES(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[2]), .out_ready(out_ready),
    .sum(sm[2]), .cout(co[2]), .overflow(of[2])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  // Returns {cout, overflow, sum}.
  function automatic logic [W+1:0] model(input beat_t x);
    int ua, ub, sa, sb, ci, u, s;
    logic c, o;
    ua = int'(x.a);
    ub = int'(x.b);
    sa = int'($signed(x.a));
    sb = int'($signed(x.b));
    ci = x.cin ? 1 : 0;
    if (x.sub) begin
      u = ua - ub;
      s = sa - sb;
      c = (ua >= ub);
    end else begin
      u = ua + ub + ci;
      s = sa + sb + ci;
      c = (u > 65535);
    end
    o = (s > 32767) || (s < -32768);
    return {c, o, u[W-1:0]};
  endfunction

  // Streaming engine for instance 0: source queue, scoreboard, hold tracking.
  beat_t        src_q [$];
  logic [W+1:0] exp_q [$];
  int           n_in  = 0;
  int           n_out = 0;
  bit           hold  = 1'b0;
  logic [W+1:0] held;

  // Called at a falling edge; drives one cycle and returns at the next one.
  task automatic step(input bit want, input bit ordy);
    if (want && src_q.size() > 0) begin
      a     = src_q[0].a;
      b     = src_q[0].b;
      cin   = src_q[0].cin;
      sub   = src_q[0].sub;
      iv[0] = 1'b1;
    end else begin
      iv[0] = 1'b0;
    end
    out_ready = ordy;
    #1;
    if (hold) begin
      check("hold_valid", ov[0], 1'b1);
      check("hold_data", {co[0], of[0], sm[0]}, held);
    end
    if (ov[0] && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", ov[0], 1'b0);
      else check("stream_result", {co[0], of[0], sm[0]}, exp_q.pop_front());
      n_out++;
    end
    if (iv[0] && ir[0]) begin
      exp_q.push_back(model(src_q.pop_front()));
      n_in++;
    end
    hold = ov[0] && !out_ready;
    held = {co[0], of[0], sm[0]};
    @(negedge clk);
  endtask

  function automatic beat_t rand_beat();
    beat_t x;
    x.a   = W'($urandom);
    x.b   = W'($urandom);
    x.cin = 1'($urandom_range(0, 1));
    x.sub = 1'($urandom_range(0, 1));
    return x;
  endfunction

  // One isolated beat into instance idx; checks latency and result.
  task automatic run_vec(input int idx, input vec_t v, input int lat);
    int cyc;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    out_ready = 1'b1;
    iv[idx] = 1'b1;
    #1;
    check($sformatf("vec_in_ready[s%0d]", lat), ir[idx], 1'b1);
    @(negedge clk);
    iv[idx] = 1'b0;
    cyc = 1;
    while (!ov[idx] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("vec_latency[s%0d]", lat), cyc, lat);
    check($sformatf("vec_sum[s%0d %h%s%h]", lat, v.a, v.sub ? "-" : "+", v.b), sm[idx], v.sum);
    check($sformatf("vec_cout[s%0d %h%s%h]", lat, v.a, v.sub ? "-" : "+", v.b), co[idx], v.cout);
    check($sformatf("vec_ovf[s%0d %h%s%h]", lat, v.a, v.sub ? "-" : "+", v.b), of[idx], v.ovf);
    @(negedge clk);
    check($sformatf("vec_drained[s%0d]", lat), ov[idx], 1'b0);
  endtask

  vec_t vecs [7];
  int   stg  [3];

  initial begin
    int steps;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0};
    vecs[5] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    stg[0] = 4; stg[1] = 1; stg[2] = 16;

    a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) iv[i] = 1'b0;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_out_valid[s%0d]", stg[i]), ov[i], 1'b0);
      check($sformatf("rst_sum[s%0d]", stg[i]), sm[i], '0);
      check($sformatf("rst_cout[s%0d]", stg[i]), co[i], 1'b0);
      check($sformatf("rst_ovf[s%0d]", stg[i]), of[i], 1'b0);
      check($sformatf("rst_in_ready[s%0d]", stg[i]), ir[i], 1'b1);
    end
    @(negedge clk);

    // Directed vectors on every pipeline depth
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 7; j++)
        run_vec(i, vecs[j], stg[i]);

    // 100 back-to-back random beats, no back-pressure
    n_in = 0; n_out = 0; hold = 1'b0;
    for (int i = 0; i < 100; i++) src_q.push_back(rand_beat());
    steps = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && steps < 500) begin
      step(1'b1, 1'b1);
      steps++;
    end
    check("t3_cycles", steps, 104);
    check("t3_outputs", n_out, 100);

    // Back-pressure: 6 beats offered with out_ready low
    n_in = 0; n_out = 0;
    for (int i = 0; i < 6; i++) src_q.push_back(rand_beat());
    repeat (8) step(1'b1, 1'b0);
    check("t4_accepted_full", n_in, 4);
    check("t4_in_ready_full", ir[0], 1'b0);
    check("t4_out_valid_full", ov[0], 1'b1);
    steps = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && steps < 100) begin
      step(1'b1, 1'b1);
      steps++;
    end
    check("t4_accepted", n_in, 6);
    check("t4_outputs", n_out, 6);

    // Random handshake toggling over 1000 beats
    n_in = 0; n_out = 0;
    for (int i = 0; i < 1000; i++) src_q.push_back(rand_beat());
    steps = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && steps < 20000) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      steps++;
    end
    check("t5_accepted", n_in, 1000);
    check("t5_outputs", n_out, 1000);

    // Reset with 3 beats in flight
    n_in = 0;
    for (int i = 0; i < 3; i++) src_q.push_back(rand_beat());
    steps = 0;
    while (n_in < 3 && steps < 10) begin
      step(1'b1, 1'b0);
      steps++;
    end
    check("t6_loaded", n_in, 3);
    iv[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t6_out_valid", ov[0], 1'b0);
    check("t6_sum", sm[0], '0);
    check("t6_cout", co[0], 1'b0);
    check("t6_ovf", of[0], 1'b0);
    check("t6_in_ready", ir[0], 1'b1);
    reset = 1'b0;
    exp_q.delete();
    src_q.delete();
    hold = 1'b0;
    n_out = 0;
    repeat (10) step(1'b0, 1'b1);
    check("t6_no_stale", n_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
